// File: rtl/madv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : madv_pkg
//  Description : Shared types and constants for the MAC dot-product
//                accelerator requantisation stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package madv_pkg;

  // Width of one dot-product result produced by the accelerator
  localparam int MADV_RES_W = 32;

  // int8 saturation bounds
  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

  // Configuration register select
  typedef enum logic [1:0] {
    CFG_BIAS  = 2'd0,
    CFG_MULT  = 2'd1,
    CFG_SHIFT = 2'd2,
    CFG_ZP    = 2'd3
  } cfg_sel_e;

  // Width-fixed part of the requantisation configuration
  typedef struct packed {
    logic [MADV_RES_W-1:0] bias;  // signed additive bias
    logic [7:0]            zp;    // signed output zero-point
  } requant_cfg_t;

endpackage : madv_pkg
`default_nettype wire

// File: rtl/madv_requant_pack.sv
`default_nettype none
// ============================================================================
//  Module      : madv_requant_pack
//  Description : int8 lane packer. Collects requantised lanes into a word,
//                handles the pending-flush flag and owns the output register
//                with valid/ready backpressure. The stall it derives freezes
//                the whole upstream pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module madv_requant_pack
  import madv_pkg::*;
#(
  parameter int PACK_LANES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s3_valid_i,
  input  logic [7:0]  s3_data_i,
  input  logic        pipe_empty_i,
  input  logic        flush_i,
  input  logic        out_ready_i,
  output logic        adv_o,
  output logic        flush_pend_o,
  output logic        lanes_busy_o,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  output logic [2:0]  out_count_o
);

  localparam logic [2:0] C_LANES = 3'(PACK_LANES);

  logic [PACK_LANES-1:0][7:0] lanes_q, lanes_d, lanes_wr;
  logic [2:0]                 cnt_q, cnt_d, cnt_inc;
  logic                       pend_q, pend_d;
  logic                       out_valid_q, out_valid_d;
  logic [31:0]                out_data_q, out_data_d, word;
  logic [2:0]                 out_count_q, out_count_d;
  logic                       stall, wr, full, flush_go, flush_emit;

  // Handshake: a held, untaken output word freezes everything upstream
  always_comb begin
    stall      = out_valid_q & ~out_ready_i;
    wr         = ~stall & s3_valid_i;
    cnt_inc    = cnt_q + 3'd1;
    full       = wr && (cnt_inc == C_LANES);
    // An empty pipeline means no lane is written in the same cycle
    flush_go   = pend_q & pipe_empty_i & ~stall;
    flush_emit = flush_go & (cnt_q != 3'd0);
  end

  // Lane write and word assembly; unwritten lanes are zero
  always_comb begin
    lanes_wr = lanes_q;
    for (int k = 0; k < PACK_LANES; k++) begin
      if (wr && (cnt_q == 3'(k))) lanes_wr[k] = s3_data_i;
    end
    word = '0;
    for (int k = 0; k < PACK_LANES; k++) begin
      word[8*k +: 8] = lanes_wr[k];
    end
  end

  // Next state for the lane counter, flush flag and output register
  always_comb begin
    lanes_d     = lanes_wr;
    cnt_d       = cnt_q;
    pend_d      = flush_i | (pend_q & ~flush_go);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (full || flush_go) begin
      lanes_d = '0;
      cnt_d   = 3'd0;
    end else if (wr) begin
      cnt_d   = cnt_inc;
    end
    if (full) begin
      out_valid_d = 1'b1;
      out_data_d  = word;
      out_count_d = C_LANES;
    end else if (flush_emit) begin
      out_valid_d = 1'b1;
      out_data_d  = word;
      out_count_d = cnt_q;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lanes_q     <= '0;
      cnt_q       <= 3'd0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_count_q <= 3'd0;
    end else begin
      lanes_q     <= lanes_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign adv_o        = ~stall;
  assign flush_pend_o = pend_q;
  assign lanes_busy_o = (cnt_q != 3'd0);
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_count_o  = out_count_q;

endmodule : madv_requant_pack
`default_nettype wire

// File: rtl/madv_requant.sv
`default_nettype none
// ============================================================================
//  Module      : madv_requant
//  Description : Requantisation stage of the MAC dot-product accelerator.
//                bias add -> unsigned scale multiply -> rounding shift,
//                zero-point and int8 clamp, then lane packing for writeback.
//                Optional feature macro: MADV_REQUANT_RELU_EN (stores the
//                relu bit; relu clamps the lower bound to the zero-point).
//  Revision    : 1.0 - initial release
// ============================================================================
module madv_requant
  import madv_pkg::*;
#(
  parameter int PACK_LANES = 4,
  parameter int MULT_W     = 16,
  parameter int SHIFT_W    = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_valid_i,
  input  logic [1:0]  cfg_sel_i,
  input  logic [31:0] cfg_data_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  input  logic        flush_i,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  output logic [2:0]  out_count_o,
  input  logic        out_ready_i,
  output logic        busy_o
);

  localparam int A_W = MADV_RES_W + 1;     // bias sum, cannot overflow
  localparam int P_W = A_W + MULT_W + 1;   // signed product width

  requant_cfg_t          cfg_q;
  logic [MULT_W-1:0]     mult_q;
  logic [SHIFT_W-1:0]    shift_q;
  logic                  relu;

  logic                  v1_q, v2_q, v3_q;
  logic signed [A_W-1:0] a1_q, a_d;
  logic signed [P_W-1:0] p2_q, p_d;
  logic [7:0]            lane3_q, lane_d;

  logic                  adv, pend, lanes_busy, in_fire, cfg_we;
  logic signed [P_W-1:0] mul_a, mul_b, rnd, rsum, rshr, vsum, lo;

  assign in_fire = in_valid_i & in_ready_o;
  assign cfg_we  = cfg_valid_i & ~busy_o;

  // Configuration registers, writable only while the block is idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_q   <= '0;
      mult_q  <= MULT_W'(1);
      shift_q <= '0;
    end else if (cfg_we) begin
      unique case (cfg_sel_e'(cfg_sel_i))
        CFG_BIAS:  cfg_q.bias <= cfg_data_i;
        CFG_MULT:  mult_q     <= cfg_data_i[MULT_W-1:0];
        CFG_SHIFT: shift_q    <= cfg_data_i[SHIFT_W-1:0];
        CFG_ZP:    cfg_q.zp   <= cfg_data_i[7:0];
      endcase
    end
  end

`ifdef MADV_REQUANT_RELU_EN
  logic relu_q;
  // relu flag shares the zero-point register select
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      relu_q <= 1'b0;
    else if (cfg_we && (cfg_sel_e'(cfg_sel_i) == CFG_ZP))
      relu_q <= cfg_data_i[8];
  end
  assign relu = relu_q;
`else
  assign relu = 1'b0;
`endif

  // Arithmetic for all three stages
  always_comb begin
    a_d   = A_W'($signed(in_data_i)) + A_W'($signed(cfg_q.bias));
    mul_a = P_W'(a1_q);
    mul_b = P_W'({1'b0, mult_q});
    p_d   = mul_a * mul_b;
    rnd   = '0;
    if (shift_q != '0) rnd = P_W'(1) <<< (shift_q - SHIFT_W'(1));
    rsum  = p2_q + rnd;
    rshr  = rsum >>> shift_q;
    vsum  = rshr + P_W'($signed(cfg_q.zp));
    lo    = relu ? P_W'($signed(cfg_q.zp)) : P_W'(INT8_MIN);
    if (vsum > P_W'(INT8_MAX))
      lane_d = 8'(INT8_MAX);
    else if (vsum < lo)
      lane_d = lo[7:0];
    else
      lane_d = vsum[7:0];
  end

  // Pipeline registers; every stage holds while the output is stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      a1_q    <= '0;
      p2_q    <= '0;
      lane3_q <= '0;
    end else if (adv) begin
      v1_q    <= in_fire;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      a1_q    <= a_d;
      p2_q    <= p_d;
      lane3_q <= lane_d;
    end
  end

  madv_requant_pack #(
    .PACK_LANES (PACK_LANES)
  ) u_pack (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .s3_valid_i   (v3_q),
    .s3_data_i    (lane3_q),
    .pipe_empty_i (~(v1_q | v2_q | v3_q)),
    .flush_i      (flush_i),
    .out_ready_i  (out_ready_i),
    .adv_o        (adv),
    .flush_pend_o (pend),
    .lanes_busy_o (lanes_busy),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_count_o  (out_count_o)
  );

  // New input is held off while stalled or while a flush is outstanding
  assign in_ready_o = adv & ~pend;
  assign busy_o     = v1_q | v2_q | v3_q | lanes_busy | out_valid_o | pend;

endmodule : madv_requant
`default_nettype wire

// File: tb/tb_madv_requant.sv
`default_nettype none
// ============================================================================
//  Module      : tb_madv_requant
//  Description : Directed self-checking bench for madv_requant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_madv_requant;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_valid_i = 1'b0;
  logic [1:0]  cfg_sel_i = 2'd0;
  logic [31:0] cfg_data_i = 32'd0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = 32'd0;
  logic        in_ready_o;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic [2:0]  out_count_o;
  logic        out_ready_i = 1'b1;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int sent, got;
  logic dropped;
  logic [31:0] words [4];

  madv_requant dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_sel_i   (cfg_sel_i),
    .cfg_data_i  (cfg_data_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_count_o (out_count_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
    cfg_valid_i = 1'b1;
    cfg_sel_i   = sel;
    cfg_data_i  = data;
    tick();
    cfg_valid_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] data);
    int k = 0;
    in_valid_i = 1'b1;
    in_data_i  = data;
    #0;
    while (!in_ready_o && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) chk("send_timeout", 32'(in_ready_o), 32'd1);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  // Waits (bounded) for a word, checks it, and lets it be consumed
  task automatic expect_word(input string tag, input logic [31:0] data, input logic [2:0] cnt);
    int k = 0;
    while (!out_valid_o && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
    chk({tag, "_data"}, out_data_o, data);
    chk({tag, "_count"}, 32'(out_count_o), 32'(cnt));
    tick();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_out_data", out_data_o, 32'd0);
    chk("rst_out_count", 32'(out_count_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // Default config, latency of four edges after the last lane
    send(32'd1); send(32'd2); send(32'd3); send(32'd4);
    tick(); tick();
    chk("lat_early", 32'(out_valid_o), 32'd0);
    tick();
    chk("lat_valid", 32'(out_valid_o), 32'd1);
    chk("lat_data", out_data_o, 32'h04030201);
    chk("lat_count", 32'(out_count_o), 32'd4);
    tick();
    chk("lat_taken", 32'(out_valid_o), 32'd0);
    chk("lat_idle", 32'(busy_o), 32'd0);

    // Rounding shift: 300,-300,0,8 >> 4
    cfg_write(2'd2, 32'd4);
    send(32'd300); send(-32'sd300); send(32'd0); send(32'd8);
    expect_word("shift4", 32'h0100ED13, 3'd4);
    cfg_write(2'd2, 32'd0);

    // Bias applied when written while idle
    cfg_write(2'd0, 32'd10);
    send(32'd1); send(32'd2); send(32'd3); send(32'd4);
    expect_word("bias10", 32'h0E0D0C0B, 3'd4);
    cfg_write(2'd0, 32'd0);

    // Saturation and partial flush; input held off while flush pends
    send(32'd1000); send(-32'sd1000);
    pulse_flush();
    in_valid_i = 1'b1;
    in_data_i  = 32'd77;
    #0;
    chk("flush_holdoff", 32'(in_ready_o), 32'd0);
    in_valid_i = 1'b0;
    expect_word("sat_flush", 32'h0000807F, 3'd2);

    // Flush with nothing packed emits nothing
    pulse_flush();
    tick(); tick();
    chk("flush_empty_valid", 32'(out_valid_o), 32'd0);
    chk("flush_empty_busy", 32'(busy_o), 32'd0);

    // Zero-point with relu request
    cfg_write(2'd3, 32'h0000_0103);
    send(-32'sd50);
    pulse_flush();
`ifdef MADV_REQUANT_RELU_EN
    expect_word("relu", 32'h00000003, 3'd1);
`else
    expect_word("relu", 32'h000000D1, 3'd1);
`endif
    cfg_write(2'd3, 32'd0);

    // Backpressure: output held for the first 10 cycles while 8 inputs stream
    sent = 0; got = 0; dropped = 1'b0;
    for (int cyc = 0; cyc < 80 && !(sent == 8 && got == 2); cyc++) begin
      out_ready_i = (cyc >= 10);
      in_valid_i  = (sent < 8);
      in_data_i   = 32'(sent + 1);
      @(negedge clk_i);
      if (!in_ready_o) dropped = 1'b1;
      if (in_valid_i && in_ready_o) sent++;
      if (out_valid_o && out_ready_i && got < 4) begin
        words[got] = out_data_o;
        got++;
      end
      tick();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    chk("bp_ready_dropped", 32'(dropped), 32'd1);
    chk("bp_sent", 32'(sent), 32'd8);
    chk("bp_words", 32'(got), 32'd2);
    chk("bp_word0", words[0], 32'h04030201);
    chk("bp_word1", words[1], 32'h08070605);
    tick();

    // Config write while busy is ignored
    send(32'd5);
    chk("busy_flag", 32'(busy_o), 32'd1);
    cfg_write(2'd0, 32'd100);
    pulse_flush();
    expect_word("busy_cfg", 32'h00000005, 3'd1);

    // Reset mid-packet discards the partial word
    send(32'd1); send(32'd2);
    tick(); tick(); tick();
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_data", out_data_o, 32'd0);
    chk("mid_rst_count", 32'(out_count_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    send(32'd9); send(32'd10); send(32'd11); send(32'd12);
    expect_word("post_rst", 32'h0C0B0A09, 3'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_madv_requant
`default_nettype wire
